instr_fetch_stage: RTL and testbench



---
 rtl/instr_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: owns the fetch PC, issues word requests to instruction
// memory over req/gnt/rvalid, and pairs each returned word with its PC in a
// small prefetch FIFO whose head is presented to the IF/ID register.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        f_valid,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);
    localparam int FPW        = $clog2(FIFO_DEPTH);
    localparam int FCW        = $clog2(FIFO_DEPTH + 1);
    localparam int QPW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QCW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int PEND_SLOTS = 1 << QPW;
    // Back-to-back redirects can stack killed requests beyond one window of
    // outstanding ones, so the kill counter gets some headroom.
    localparam int KCW        = QCW + 3;

    logic [31:0]    pc_q;
    logic [31:0]    fifo_instr [FIFO_DEPTH];
    logic [31:0]    fifo_pc    [FIFO_DEPTH];
    logic [FPW-1:0] fifo_rd;
    logic [FPW-1:0] fifo_wr;
    logic [FCW-1:0] fifo_count;
    logic [31:0]    pend_pc    [PEND_SLOTS];
    logic [QPW-1:0] pend_rd;
    logic [QPW-1:0] pend_wr;
    logic [QCW-1:0] outstanding;
    logic [KCW-1:0] kill_cnt;

    logic           handshake;
    logic           accept;
    logic           pop;
    logic           in_flight;
    logic [KCW-1:0] kill_redirect;
    logic           unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // Issue credit, response acceptance and FIFO head presentation.
    always_comb begin
        imem_req  = reset_n && !redirect_valid
                  && ((32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH))
                  && (32'(outstanding) < 32'(MAX_OUTSTANDING));
        imem_addr = pc_q;
        handshake = imem_req && imem_gnt;
        in_flight = (kill_cnt != '0) || (outstanding != '0);
        // A response is ours only when nothing killed is still ahead of it.
        accept    = imem_rvalid && !redirect_valid && (kill_cnt == '0)
                  && (outstanding != '0);
        f_valid   = (fifo_count != '0);
        pop       = f_valid && !stall && !redirect_valid;
        // Everything still in flight becomes junk on a redirect, except a
        // response landing in the same cycle, which is dropped right here.
        kill_redirect = kill_cnt + KCW'(outstanding)
                      - KCW'(imem_rvalid && in_flight);
        f_instr   = '0;
        f_pc      = '0;
        if (f_valid) begin
            f_instr = fifo_instr[fifo_rd];
            f_pc    = fifo_pc[fifo_rd];
        end
    end

    // PC, pending-PC queue pointers and kill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            pend_rd     <= '0;
            pend_wr     <= '0;
            outstanding <= '0;
            kill_cnt    <= '0;
        end else if (redirect_valid) begin
            pc_q        <= {redirect_pc[31:2], 2'b00};
            pend_rd     <= '0;
            pend_wr     <= '0;
            outstanding <= '0;
            kill_cnt    <= kill_redirect;
        end else begin
            if (handshake) begin
                pc_q    <= pc_q + 32'd4;
                pend_wr <= pend_wr + 1'b1;
            end
            if (accept) begin
                pend_rd <= pend_rd + 1'b1;
            end
            outstanding <= outstanding + QCW'(handshake) - QCW'(accept);
            if (imem_rvalid && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - 1'b1;
            end
        end
    end

    // Remember the address of every accepted request until its word returns.
    always_ff @(posedge clk) begin
        if (handshake) begin
            pend_pc[pend_wr] <= pc_q;
        end
    end

    // Prefetch FIFO occupancy and pointers; a redirect flushes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                fifo_wr <= fifo_wr + 1'b1;
            end
            if (pop) begin
                fifo_rd <= fifo_rd + 1'b1;
            end
            fifo_count <= fifo_count + FCW'(accept) - FCW'(pop);
        end
    end

    // FIFO payload: returned word paired with the oldest pending PC.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_instr[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
        end
    end

`ifdef FETCH_PERF_EN
    // Delivered-instruction and decode-stall counters, frozen on redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (!redirect_valid) begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (f_valid && stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A response with nothing issued and nothing to kill has no owner.
    stray_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rvalid && (outstanding == '0) && (kill_cnt == '0)));
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed phases plus randomized
// traffic against a transaction-level model (queues of in-flight requests and
// buffered instructions).
module tb_instr_fetch_stage;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;
    localparam int          FIFO_DEPTH      = 2;
    localparam int          MAX_OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] m_fetched;
    logic [31:0] m_stalled;
`endif

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .f_valid(f_valid),
        .f_instr(f_instr),
        .f_pc(f_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          live;
        int          ready;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] m_pc;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          mem_min;
    int          mem_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].live) n++;
        return n;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset_n        = 1'b0;
            stall          = 1'($urandom_range(1));
            redirect_valid = 1'b0;
            imem_gnt       = 1'b1;
            imem_rvalid    = 1'b1;
            imem_rdata     = $urandom;
            #1;
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_f_valid", 32'(f_valid), 32'd0);
            chk("rst_f_instr", f_instr, 32'd0);
            chk("rst_f_pc", f_pc, 32'd0);
            chk("rst_imem_addr", imem_addr, RESET_PC);
            cyc++;
        end
        inflight.delete();
        fifo_m.delete();
        m_pc = RESET_PC;
`ifdef FETCH_PERF_EN
        m_fetched = '0;
        m_stalled = '0;
`endif
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit gn);
        bit          exp_req;
        bit          rv;
        bit          push_resp;
        req_t        r;
        ent_t        e;
        logic [31:0] exp_fpc;
        logic [31:0] exp_fin;
        @(negedge clk);
        reset_n        = 1'b1;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = gn;
        rv             = (inflight.size() > 0) && (inflight[0].ready <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? inflight[0].data : $urandom;
        #1;
        exp_req = !rd && ((fifo_m.size() + live_cnt()) < FIFO_DEPTH)
                  && (live_cnt() < MAX_OUTSTANDING);
        exp_fpc = (fifo_m.size() > 0) ? fifo_m[0].pc : 32'd0;
        exp_fin = (fifo_m.size() > 0) ? fifo_m[0].instr : 32'd0;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("f_valid", 32'(f_valid), 32'(fifo_m.size() > 0));
        chk("f_pc", f_pc, exp_fpc);
        chk("f_instr", f_instr, exp_fin);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stalled);
        if (!rd && fifo_m.size() > 0) begin
            if (st) m_stalled = m_stalled + 32'd1;
            else    m_fetched = m_fetched + 32'd1;
        end
`endif
        push_resp = 1'b0;
        if (rv) begin
            r = inflight.pop_front();
            push_resp = r.live && !rd;
            e.instr = r.data;
            e.pc    = r.addr;
        end
        if (rd) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].live = 1'b0;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (fifo_m.size() > 0 && !st) fifo_m.delete(0);
            if (push_resp) fifo_m.push_back(e);
        end
        if (exp_req && gn) begin
            r.addr  = m_pc;
            r.data  = $urandom;
            r.live  = 1'b1;
            r.ready = cyc + 1 + int'($urandom_range(mem_max, mem_min));
            inflight.push_back(r);
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic rand_steps(input int n);
        bit          st;
        bit          rd;
        bit          gn;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            st  = ($urandom_range(99) < 30);
            rd  = ($urandom_range(99) < 5);
            gn  = ($urandom_range(99) < 75);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                                           : 32'($urandom);
            step(st, rd, rpc, gn);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        mem_min = 0;
        mem_max = 0;
        m_pc    = RESET_PC;

        // Reset, then streaming with a one-cycle memory and gnt always high.
        do_reset(3);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Decode stall held for five cycles mid-stream, then released.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Slow memory so two requests are outstanding, then redirect to 0x100.
        mem_min = 3;
        mem_max = 3;
        for (int i = 0; i < 20 && live_cnt() < 2; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("two_outstanding_before_redirect", 32'(live_cnt()), 32'd2);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        mem_min = 0;
        mem_max = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Misaligned redirect target is word-aligned.
        step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Grant withheld for three cycles: request and address hold.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // PC wraps past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic with variable memory latency.
        mem_min = 0;
        mem_max = 3;
        rand_steps(1500);

        // Reset mid-operation with requests in flight; stray rvalids during reset.
        mem_min = 2;
        mem_max = 2;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
        do_reset(3);
        mem_min = 0;
        mem_max = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

        mem_max = 3;
        rand_steps(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
